rs232_tx_fifo: RTL and testbench

Byte-wide transmit buffer sitting directly upstream of the RS232_TX transmitter in the rs232 design. It accepts bursts of bytes from a producer, such as RX echo logic or a message generator. It drains them one at a time into RS232_TX using that block's tx_vld pulse / tx_rdy status handshake. This removes the need for producers to pace themselves to the 9600-baud line rate.

---
 rtl/rs232_tx_fifo_pkg.sv | 14 +
 rtl/rs232_tx_fifo_sync_fifo_ram.sv | 24 ++
 rtl/rs232_tx_fifo.sv | 118 +++++++++++
 tb/tb_rs232_tx_fifo.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rs232_tx_fifo_pkg.sv
// Shared rs232 definitions: byte width and the transmit-buffer read state encoding.
package rs232_tx_fifo_pkg;

   localparam int BYTE_W = 8;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      LOAD      = 3'd1,
      SEND      = 3'd2,
      WAIT_BUSY = 3'd3,
      WAIT_DONE = 3'd4
   } tx_state_t;

endpackage

// File: rtl/rs232_tx_fifo_sync_fifo_ram.sv
// Byte storage for the transmit buffer: synchronous write port, asynchronous read port.
module sync_fifo_ram
   import rs232_tx_fifo_pkg::*;
#(
   parameter int DEPTH  = 16,
   parameter int ADDR_W = 4
) (
   input  logic              clock,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [BYTE_W-1:0] wr_data,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [BYTE_W-1:0] rd_data
);

   logic [BYTE_W-1:0] mem [DEPTH];

   always_ff @(posedge clock) begin
      if (wr_en) mem[wr_addr] <= wr_data;
   end

   assign rd_data = mem[rd_addr];

endmodule

// File: rtl/rs232_tx_fifo.sv
// Transmit buffer ahead of RS232_TX: queues producer bytes and hands them over one
// at a time with the tx_vld pulse / tx_rdy status handshake.
//
//   state     | meaning
//   ----------+-----------------------------------------------------------------
//   IDLE      | waiting for a queued byte while the transmitter reports ready
//   LOAD      | pop head byte into transmit_data
//   SEND      | tx_vld pulse (one cycle)
//   WAIT_BUSY | waiting for tx_rdy to fall; gives up after BUSY_TO cycles
//   WAIT_DONE | transmitter busy; waiting for tx_rdy to return high
module rs232_tx_fifo
   import rs232_tx_fifo_pkg::*;
#(
   parameter int DEPTH   = 16,
   parameter int ADDR_W  = 4,
   parameter int BUSY_TO = 16
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              wr_vld,
   input  logic [BYTE_W-1:0] wr_data,
   output logic              wr_full,
   output logic [ADDR_W:0]   level,
   output logic              overflow,
   input  logic              ovf_clr,
   output logic              tx_vld,
   output logic [BYTE_W-1:0] transmit_data,
   input  logic              tx_rdy
);

   localparam int CNT_W = $clog2(BUSY_TO + 1);

   tx_state_t         state;
   logic [ADDR_W-1:0] wr_ptr;
   logic [ADDR_W-1:0] rd_ptr;
   logic [CNT_W-1:0]  busy_cnt;
   logic [BYTE_W-1:0] rd_byte;
   logic [ADDR_W:0]   level_next;
   logic              wr_accept;
   logic              wr_drop;
   logic              pop;

   // Full decision uses the registered flag, so a pop in the same cycle never frees a slot early.
   assign wr_accept = wr_vld & ~wr_full;
   assign wr_drop   = wr_vld &  wr_full;
   assign pop       = (state == LOAD);

   always_comb begin
      level_next = level;
      if (wr_accept && !pop)      level_next = level + 1'b1;
      else if (!wr_accept && pop) level_next = level - 1'b1;
   end

   sync_fifo_ram #(
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W)
   ) u_ram (
      .clock   (clock),
      .wr_en   (wr_accept),
      .wr_addr (wr_ptr),
      .wr_data (wr_data),
      .rd_addr (rd_ptr),
      .rd_data (rd_byte)
   );

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         wr_ptr   <= '0;
         level    <= '0;
         wr_full  <= 1'b0;
         overflow <= 1'b0;
      end else begin
         if (wr_accept) wr_ptr <= wr_ptr + 1'b1;
         level   <= level_next;
         wr_full <= (level_next == (ADDR_W + 1)'(DEPTH));
         if (wr_drop)      overflow <= 1'b1;
         else if (ovf_clr) overflow <= 1'b0;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state         <= IDLE;
         rd_ptr        <= '0;
         busy_cnt      <= '0;
         tx_vld        <= 1'b0;
         transmit_data <= '0;
      end else begin
         tx_vld <= 1'b0;
         case (state)
            IDLE: begin
               if (level != '0 && tx_rdy) state <= LOAD;
            end
            LOAD: begin
               transmit_data <= rd_byte;
               rd_ptr        <= rd_ptr + 1'b1;
               tx_vld        <= 1'b1;
               state         <= SEND;
            end
            SEND: begin
               busy_cnt <= '0;
               state    <= WAIT_BUSY;
            end
            WAIT_BUSY: begin
               // A transmitter that never reports busy must not stall the queue forever.
               if (!tx_rdy)                                  state <= WAIT_DONE;
               else if (busy_cnt == CNT_W'(BUSY_TO - 1))     state <= IDLE;
               else                                          busy_cnt <= busy_cnt + 1'b1;
            end
            WAIT_DONE: begin
               if (tx_rdy) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_rs232_tx_fifo.sv
// Bench for rs232_tx_fifo: queue-and-timestamp model checked every cycle, plus directed
// scenarios with hand-computed timing and data expectations.
module tb_rs232_tx_fifo;

   localparam int DEPTH   = 16;
   localparam int BUSY_TO = 16;

   logic       clock = 1'b0;
   logic       reset = 1'b0;
   logic       wr_vld = 1'b0;
   logic [7:0] wr_data = 8'h00;
   logic       ovf_clr = 1'b0;
   logic       tx_rdy = 1'b1;
   logic       wr_full;
   logic [4:0] level;
   logic       overflow;
   logic       tx_vld;
   logic [7:0] transmit_data;

   rs232_tx_fifo #(
      .DEPTH   (DEPTH),
      .ADDR_W  (4),
      .BUSY_TO (BUSY_TO)
   ) dut (
      .clock         (clock),
      .reset         (reset),
      .wr_vld        (wr_vld),
      .wr_data       (wr_data),
      .wr_full       (wr_full),
      .level         (level),
      .overflow      (overflow),
      .ovf_clr       (ovf_clr),
      .tx_vld        (tx_vld),
      .transmit_data (transmit_data),
      .tx_rdy        (tx_rdy)
   );

   always #10 clock = ~clock;

   int n_cmp  = 0;
   int n_fail = 0;
   int cyc    = 0;
   int tx_mode = 0;   // 0: frame model, 1: always ready, 2: never ready

   // Model: bytes held, last byte handed over, and timestamps for the hand-over schedule.
   logic [7:0] mq[$];
   logic [7:0] m_data = 8'h00;
   bit         m_ovf = 1'b0;
   int         pulse_at = -1;
   int         free_at = 0;
   int         watch_from = 0;
   bit         watching = 1'b0;
   bit         seen_low = 1'b0;
   int         vld_cycles[$];
   logic [7:0] sent[$];

   // Transmitter stand-in: busy for 20 cycles starting the cycle after each tx_vld.
   initial begin : tx_model
      int busy_left;
      bit vld_now;
      busy_left = 0;
      forever begin
         @(negedge clock);
         vld_now = tx_vld;
         @(posedge clock);
         #2;
         if (tx_mode == 1) begin
            busy_left = 0;
            tx_rdy = 1'b1;
         end else if (tx_mode == 2) begin
            busy_left = 0;
            tx_rdy = 1'b0;
         end else begin
            if (vld_now) busy_left = 20;
            if (busy_left > 0) begin
               tx_rdy = 1'b0;
               busy_left--;
            end else begin
               tx_rdy = 1'b1;
            end
         end
      end
   end

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", nm, got, exp, cyc);
      end
   endtask

   task automatic model_cycle();
      int sz;
      bit drop;
      if (!reset) begin
         mq.delete();
         m_ovf    = 1'b0;
         m_data   = 8'h00;
         pulse_at = -1;
         free_at  = 0;
         watching = 1'b0;
         seen_low = 1'b0;
         chk("reset_level", level, 0);
         chk("reset_vld", tx_vld, 0);
         chk("reset_data", transmit_data, 0);
         chk("reset_full", wr_full, 0);
         chk("reset_ovf", overflow, 0);
      end else begin
         sz = mq.size();
         chk("level", level, sz);
         chk("wr_full", wr_full, (sz == DEPTH));
         chk("overflow", overflow, m_ovf);
         chk("tx_vld", tx_vld, (cyc == pulse_at));
         chk("transmit_data", transmit_data, m_data);
         if (tx_vld) begin
            vld_cycles.push_back(cyc);
            sent.push_back(transmit_data);
         end
         drop = wr_vld && (sz == DEPTH);
         if (cyc == pulse_at - 1 && mq.size() > 0) m_data = mq.pop_front();
         if (wr_vld && !drop) mq.push_back(wr_data);
         if (drop)         m_ovf = 1'b1;
         else if (ovf_clr) m_ovf = 1'b0;
         // Hand-over schedule: a start pops one cycle later and pulses two cycles later.
         if (cyc == pulse_at) begin
            watching   = 1'b1;
            seen_low   = 1'b0;
            watch_from = cyc;
            pulse_at   = -1;
         end else if (watching) begin
            if (!seen_low) begin
               if (!tx_rdy) seen_low = 1'b1;
               else if (cyc == watch_from + BUSY_TO) begin
                  watching = 1'b0;
                  free_at  = cyc + 1;
               end
            end else if (tx_rdy) begin
               watching = 1'b0;
               free_at  = cyc + 1;
            end
         end else if (pulse_at < 0 && cyc >= free_at && sz != 0 && tx_rdy) begin
            pulse_at = cyc + 2;
         end
      end
   endtask

   task automatic tick();
      @(negedge clock);
      model_cycle();
      @(posedge clock);
      cyc++;
      #1;
   endtask

   task automatic put(input logic [7:0] b);
      wr_vld  = 1'b1;
      wr_data = b;
      tick();
      wr_vld  = 1'b0;
   endtask

   task automatic wait_pulses(input int target, input int budget, input string nm);
      int b;
      b = budget;
      while (vld_cycles.size() < target && b > 0) begin
         tick();
         b--;
      end
      chk(nm, vld_cycles.size(), target);
   endtask

   initial begin : watchdog
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached, cycle %0d", cyc);
      $fatal(1);
   end

   initial begin : main
      int n;
      int k;
      repeat (3) tick();
      reset = 1'b1;
      tick();
      tick();
      chk("init_level", level, 0);
      chk("init_vld", tx_vld, 0);
      chk("init_data", transmit_data, 0);
      chk("init_full", wr_full, 0);
      chk("init_ovf", overflow, 0);

      // Single byte: pulse three cycles after the write.
      n = cyc;
      k = vld_cycles.size();
      put(8'hA5);
      chk("a5_level_one", level, 1);
      wait_pulses(k + 1, 10, "a5_pulse_seen");
      if (vld_cycles.size() > k) begin
         chk("a5_latency", vld_cycles[k] - n, 3);
         chk("a5_byte", sent[k], 8'hA5);
      end
      chk("a5_level_zero", level, 0);
      repeat (30) tick();

      // Fill to full with the transmitter held off, then overflow and clear.
      tx_mode = 2;
      repeat (3) tick();
      for (int i = 0; i < 16; i++) put(8'(i));
      chk("burst_full", wr_full, 1);
      chk("burst_level", level, 16);
      put(8'hFF);
      chk("ovf_set", overflow, 1);
      chk("ovf_level", level, 16);
      repeat (2) tick();
      ovf_clr = 1'b1;
      tick();
      ovf_clr = 1'b0;
      chk("ovf_cleared", overflow, 0);
      k = vld_cycles.size();
      tx_mode = 0;
      wait_pulses(k + 16, 16 * 30, "burst_pulses");
      for (int i = 0; i < 16; i++) begin
         if (k + i < sent.size()) chk($sformatf("burst_byte%0d", i), sent[k + i], i);
      end
      if (vld_cycles.size() > k + 1) chk("frame_spacing", vld_cycles[k + 1] - vld_cycles[k], 24);
      repeat (30) tick();
      chk("burst_drained", level, 0);
      chk("ff_never_sent", vld_cycles.size(), k + 16);

      // Transmitter never goes busy: release after the busy timeout.
      tx_mode = 1;
      repeat (2) tick();
      k = vld_cycles.size();
      put(8'h11);
      put(8'h22);
      wait_pulses(k + 2, 80, "rdy_high_pulses");
      if (vld_cycles.size() > k + 1) begin
         chk("busy_to_spacing", vld_cycles[k + 1] - vld_cycles[k], 19);
         chk("rdy_high_byte0", sent[k], 8'h11);
         chk("rdy_high_byte1", sent[k + 1], 8'h22);
      end
      repeat (25) tick();

      // Transmitter never ready: bytes held until released.
      tx_mode = 2;
      repeat (2) tick();
      k = vld_cycles.size();
      put(8'h31);
      put(8'h32);
      put(8'h33);
      repeat (10) tick();
      chk("hold_level", level, 3);
      chk("hold_no_vld", vld_cycles.size(), k);
      tx_mode = 0;
      wait_pulses(k + 3, 120, "hold_release_pulses");
      for (int i = 0; i < 3; i++) begin
         if (k + i < sent.size()) chk($sformatf("hold_byte%0d", i), sent[k + i], 8'h31 + i);
      end
      repeat (30) tick();

      // Reset while the first of five bytes is in flight.
      k = vld_cycles.size();
      for (int i = 0; i < 5; i++) put(8'h41 + 8'(i));
      wait_pulses(k + 1, 20, "mid_first_pulse");
      repeat (5) tick();
      chk("mid_level", level, 4);
      reset = 1'b0;
      #1;
      chk("mid_rst_level", level, 0);
      chk("mid_rst_vld", tx_vld, 0);
      chk("mid_rst_data", transmit_data, 0);
      chk("mid_rst_full", wr_full, 0);
      tick();
      tick();
      reset = 1'b1;
      k = vld_cycles.size();
      repeat (60) tick();
      chk("no_stale_pulse", vld_cycles.size(), k);
      chk("post_rst_level", level, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
